mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single word-granularity RAM port between the icache and dcache block-fetch interfaces.
- Grants one cache at a time and serializes each 2-word block into two RAM word accesses.
- Returns the assembled block with a single-cycle hit pulse to the granted cache.
- Arbitration: dcache priority, with a bounded-starvation override for icache.

Parameters:
- WORD_W, 32, data word width.
- BLOCK_ADDR_W, 29, block address width (byte address minus 1 block-offset bit and 2 byte-offset bits).
- STARVE_LIMIT, 4, consecutive dcache grants allowed while icache waits; range 1..15.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous active-high reset.
- DUT_error  out  1  registered protocol-error flag.
- imem_REN  in  1  icache block read request; held until imem_hit.
- imem_block_addr  in  BLOCK_ADDR_W  icache block address.
- imem_hit  out  1  one-cycle pulse; imem_load valid this cycle.
- imem_load  out  2*WORD_W  block; [0]=even word, [1]=odd word.
- dmem_REN  in  1  dcache block read request.
- dmem_WEN  in  1  dcache block write request.
- dmem_block_addr  in  BLOCK_ADDR_W  dcache block address.
- dmem_store  in  2*WORD_W  dcache write block.
- dmem_hit  out  1  one-cycle completion pulse.
- dmem_load  out  2*WORD_W  dcache read block.
- ram_REN  out  1  RAM word read.
- ram_WEN  out  1  RAM word write.
- ram_addr  out  32  byte address = {block_addr, word_sel, 2'b00}.
- ram_store  out  WORD_W  write data.
- ram_load  in  WORD_W  read data, valid with ram_ready.
- ram_ready  in  1  access-complete pulse; may assert in the first cycle of a request.

Behaviour:
- States: IDLE, I_W0, I_W1, D_W0, D_W1.
  - Registered: state, granted block addr, write flag, word0 buffer, starve_cnt (4b), DUT_error.
- Reset (RST high at posedge):
  - state=IDLE, starve_cnt=0, buffers=0, DUT_error=0.
  - All ram_* and *_hit outputs 0. load outputs 0 while not hit.
- Arbitration (IDLE only):
  - dmem req = dmem_REN|dmem_WEN.
  - If dmem req and not (imem_REN and starve_cnt==STARVE_LIMIT): go to D_W0.
    - Latch addr, write=dmem_WEN.
    - starve_cnt += 1 if imem_REN, else starve_cnt = 0.
  - Else if imem_REN: go to I_W0, latch addr, starve_cnt=0.
  - Else stay in IDLE.
- Word states:
  - x_W0 drives ram_addr word_sel=0; x_W1 drives word_sel=1.
  - ram_REN (or ram_WEN for a write) is held high until ram_ready. Address and store data are stable while held.
  - W0 on ram_ready: latch ram_load into word0 buffer (reads), go to W1.
  - W1 on ram_ready: pulse hit, load = {ram_load, word0 buffer}, go to IDLE.
- Latency:
  - Request seen at cycle t in IDLE; W0 at t+1.
  - With zero-wait RAM: hit at t+2, IDLE at t+3.
  - Minimum one IDLE cycle between transactions.
- Abort: if the granted REN drops mid-read, the current word finishes, then return to IDLE with no hit.
- Write completion: writes always complete both words, even if WEN drops. dmem_hit is suppressed if WEN has dropped.
- Request changes mid-transaction: the granted address is latched, so requester address changes after grant are ignored.
- Both dmem_REN and dmem_WEN high in IDLE:
  - The request is treated as a write.
  - DUT_error=1 for exactly one cycle (next cycle).
- Never both ram_REN and ram_WEN in the same cycle; never both hits in the same cycle.
- Reset mid-transaction: returns to IDLE next cycle with ram_* deasserted. No hit is issued for the aborted transfer.

Test Plan:
- Single icache read:
  - Stimulus: imem_REN, addr 0x0000010, zero-wait RAM returning 0xAAAA0000 then 0xAAAA0001.
  - Required: ram_addr 0x00000080 then 0x00000084; imem_hit at t+2 with imem_load={0xAAAA0001,0xAAAA0000}.
- dcache write with 3-cycle-wait RAM:
  - Stimulus: addr 0x1, store {0x22,0x11}.
  - Required: ram_WEN held 3 cycles at 0x8 with data 0x11, then 3 cycles at 0xC with 0x22; dmem_hit one pulse; imem_hit 0.
- Simultaneous requests, continuously held, STARVE_LIMIT=4:
  - Stimulus: imem_REN and dmem_REN both held continuously.
  - Required: grant order D,D,D,D,I,D,D,D,D,I; starve_cnt observed 4 immediately before each I grant.
- Icache abort:
  - Stimulus: imem_REN dropped during I_W1 wait.
  - Required: word1 access completes, no imem_hit, IDLE next cycle, then a pending dmem request is granted.
- Protocol error:
  - Stimulus: dmem_REN=dmem_WEN=1.
  - Required: DUT_error pulse 1 cycle; write performed.
- Reset mid-operation:
  - Stimulus: RST asserted during D_W0.
  - Required: next cycle ram_REN=ram_WEN=0, no hits, state IDLE, starve_cnt 0; a fresh request then completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM-port signals seen by mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding caches and RAM that drive the requests and the RAM response.
interface mem_arbiter_if #(
    parameter int WORD_W       = 32,
    parameter int BLOCK_ADDR_W = 29
);
    // icache block-fetch interface
    logic                    imem_REN;
    logic [BLOCK_ADDR_W-1:0] imem_block_addr;
    logic                    imem_hit;
    logic [2*WORD_W-1:0]     imem_load;

    // dcache block interface
    logic                    dmem_REN;
    logic                    dmem_WEN;
    logic [BLOCK_ADDR_W-1:0] dmem_block_addr;
    logic [2*WORD_W-1:0]     dmem_store;
    logic                    dmem_hit;
    logic [2*WORD_W-1:0]     dmem_load;

    // single word-granularity RAM port
    logic                    ram_REN;
    logic                    ram_WEN;
    logic [31:0]             ram_addr;
    logic [WORD_W-1:0]       ram_store;
    logic [WORD_W-1:0]       ram_load;
    logic                    ram_ready;

    modport slave (
        input  imem_REN, imem_block_addr,
        output imem_hit, imem_load,
        input  dmem_REN, dmem_WEN, dmem_block_addr, dmem_store,
        output dmem_hit, dmem_load,
        output ram_REN, ram_WEN, ram_addr, ram_store,
        input  ram_load, ram_ready
    );

    modport master (
        output imem_REN, imem_block_addr,
        input  imem_hit, imem_load,
        output dmem_REN, dmem_WEN, dmem_block_addr, dmem_store,
        input  dmem_hit, dmem_load,
        input  ram_REN, ram_WEN, ram_addr, ram_store,
        output ram_load, ram_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single RAM word port between icache and dcache block fetches.
// dcache has priority, but after STARVE_LIMIT consecutive dcache grants with
// the icache waiting, the icache is granted. Each 2-word block is moved as two
// RAM word accesses; the completed block is returned with a one-cycle hit.
module mem_arbiter #(
    parameter int         WORD_W       = 32,
    parameter int         BLOCK_ADDR_W = 29,
    parameter logic [3:0] STARVE_LIMIT = 4'd4
) (
    input  logic         CLK,
    input  logic         RST,
    output logic         DUT_error,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_W0 = 3'd1,
        I_W1 = 3'd2,
        D_W0 = 3'd3,
        D_W1 = 3'd4
    } state_t;

    state_t                  r_state;
    logic [BLOCK_ADDR_W-1:0] r_addr;
    logic                    r_write;
    logic [WORD_W-1:0]       r_word0;
    logic [3:0]              r_starve_cnt;
    logic                    r_error;

    state_t                  w_state_nxt;
    logic [BLOCK_ADDR_W-1:0] w_addr_nxt;
    logic                    w_write_nxt;
    logic [WORD_W-1:0]       w_word0_nxt;
    logic [3:0]              w_starve_nxt;
    logic                    w_error_nxt;
    logic                    w_ram_ren;
    logic                    w_ram_wen;
    logic                    w_sel;
    logic                    w_ihit;
    logic                    w_dhit;
    logic                    w_dreq;
    logic                    w_istarved;

    assign w_dreq     = bus.dmem_REN | bus.dmem_WEN;
    assign w_istarved = bus.imem_REN && (r_starve_cnt == STARVE_LIMIT);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_addr       <= {BLOCK_ADDR_W{1'b0}};
            r_write      <= 1'b0;
            r_word0      <= {WORD_W{1'b0}};
            r_starve_cnt <= 4'd0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_write      <= w_write_nxt;
            r_word0      <= w_word0_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_error      <= w_error_nxt;
        end
    end

    // Arbitration, word sequencing and RAM/hit strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_write_nxt  = r_write;
        w_word0_nxt  = r_word0;
        w_starve_nxt = r_starve_cnt;
        w_error_nxt  = 1'b0;
        w_ram_ren    = 1'b0;
        w_ram_wen    = 1'b0;
        w_sel        = 1'b0;
        w_ihit       = 1'b0;
        w_dhit       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dreq && !w_istarved) begin
                    w_state_nxt  = D_W0;
                    w_addr_nxt   = bus.dmem_block_addr;
                    // REN+WEN together is a protocol error; it is served as a write
                    w_write_nxt  = bus.dmem_WEN;
                    w_error_nxt  = bus.dmem_REN & bus.dmem_WEN;
                    w_starve_nxt = bus.imem_REN ? (r_starve_cnt + 4'd1) : 4'd0;
                end else if (bus.imem_REN) begin
                    w_state_nxt  = I_W0;
                    w_addr_nxt   = bus.imem_block_addr;
                    w_write_nxt  = 1'b0;
                    w_starve_nxt = 4'd0;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            I_W0: begin
                w_ram_ren = 1'b1;
                if (bus.ram_ready) begin
                    w_word0_nxt = bus.ram_load;
                    // a dropped request finishes this word and then gives up
                    w_state_nxt = bus.imem_REN ? I_W1 : IDLE;
                end else begin
                    w_state_nxt = I_W0;
                end
            end
            I_W1: begin
                w_ram_ren = 1'b1;
                w_sel     = 1'b1;
                if (bus.ram_ready) begin
                    w_ihit      = bus.imem_REN;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = I_W1;
                end
            end
            D_W0: begin
                w_ram_ren = ~r_write;
                w_ram_wen = r_write;
                if (bus.ram_ready) begin
                    if (!r_write) begin
                        w_word0_nxt = bus.ram_load;
                    end else begin
                        w_word0_nxt = r_word0;
                    end
                    // writes always complete both words
                    w_state_nxt = (r_write || bus.dmem_REN) ? D_W1 : IDLE;
                end else begin
                    w_state_nxt = D_W0;
                end
            end
            D_W1: begin
                w_ram_ren = ~r_write;
                w_ram_wen = r_write;
                w_sel     = 1'b1;
                if (bus.ram_ready) begin
                    w_dhit      = r_write ? bus.dmem_WEN : bus.dmem_REN;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = D_W1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign DUT_error     = r_error;
    assign bus.ram_REN   = w_ram_ren;
    assign bus.ram_WEN   = w_ram_wen;
    assign bus.ram_addr  = (w_ram_ren | w_ram_wen) ? 32'({r_addr, w_sel, 2'b00}) : 32'd0;
    assign bus.ram_store = w_ram_wen ? (w_sel ? bus.dmem_store[2*WORD_W-1:WORD_W]
                                              : bus.dmem_store[WORD_W-1:0])
                                     : {WORD_W{1'b0}};
    assign bus.imem_hit  = w_ihit;
    assign bus.dmem_hit  = w_dhit;
    assign bus.imem_load = w_ihit ? {bus.ram_load, r_word0} : {(2*WORD_W){1'b0}};
    assign bus.dmem_load = w_dhit ? {bus.ram_load, r_word0} : {(2*WORD_W){1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: icache read, waited dcache write,
// starvation override, icache abort, REN+WEN protocol error, mid-transfer reset.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        DUT_error;
    int          checks;
    int          errors;
    int          ram_hold;
    logic [3:0]  ram_cnt;
    logic [31:0] rd_base;

    mem_arbiter_if #(.WORD_W(32), .BLOCK_ADDR_W(29)) bus ();

    mem_arbiter #(.WORD_W(32), .BLOCK_ADDR_W(29), .STARVE_LIMIT(4'd4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .DUT_error (DUT_error),
        .bus       (bus)
    );

    // Clock generator, 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // RAM responder: each access takes ram_hold cycles; read data is rd_base + word index.
    always @(posedge CLK) begin
        if (RST || !(bus.ram_REN || bus.ram_WEN) || bus.ram_ready) begin
            ram_cnt <= 4'd0;
        end else begin
            ram_cnt <= ram_cnt + 4'd1;
        end
    end
    assign bus.ram_ready = (bus.ram_REN || bus.ram_WEN) && (ram_cnt == 4'(ram_hold - 1));
    assign bus.ram_load  = rd_base + 32'(bus.ram_addr[2]);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ram_hold = 1;
        rd_base = 32'h0;
        RST = 1'b1;
        bus.imem_REN = 1'b0;
        bus.imem_block_addr = 29'h0;
        bus.dmem_REN = 1'b0;
        bus.dmem_WEN = 1'b0;
        bus.dmem_block_addr = 29'h0;
        bus.dmem_store = 64'h0;

        // ---- reset state ----
        cyc();
        cyc();
        chk("rst_ram_ren", 64'(bus.ram_REN), 64'd0);
        chk("rst_ram_wen", 64'(bus.ram_WEN), 64'd0);
        chk("rst_ihit", 64'(bus.imem_hit), 64'd0);
        chk("rst_dhit", 64'(bus.dmem_hit), 64'd0);
        chk("rst_err", 64'(DUT_error), 64'd0);
        chk("rst_iload", bus.imem_load, 64'd0);
        chk("rst_starve", 64'(dut.r_starve_cnt), 64'd0);
        RST = 1'b0;
        cyc();

        // ---- single icache read, zero-wait RAM ----
        rd_base = 32'hAAAA0000;
        bus.imem_REN = 1'b1;
        bus.imem_block_addr = 29'h10;
        cyc();
        chk("i1_w0_ren", 64'(bus.ram_REN), 64'd1);
        chk("i1_w0_wen", 64'(bus.ram_WEN), 64'd0);
        chk("i1_w0_addr", 64'(bus.ram_addr), 64'h80);
        chk("i1_w0_hit", 64'(bus.imem_hit), 64'd0);
        cyc();
        chk("i1_w1_addr", 64'(bus.ram_addr), 64'h84);
        chk("i1_w1_hit", 64'(bus.imem_hit), 64'd1);
        chk("i1_w1_load", bus.imem_load, 64'hAAAA0001_AAAA0000);
        chk("i1_w1_dhit", 64'(bus.dmem_hit), 64'd0);
        bus.imem_REN = 1'b0;
        cyc();
        chk("i1_idle_ren", 64'(bus.ram_REN), 64'd0);
        chk("i1_idle_hit", 64'(bus.imem_hit), 64'd0);
        chk("i1_idle_load", bus.imem_load, 64'd0);

        // ---- dcache write, 3-cycle RAM ----
        ram_hold = 3;
        bus.dmem_WEN = 1'b1;
        bus.dmem_block_addr = 29'h1;
        bus.dmem_store = {32'h22, 32'h11};
        cyc();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 3; i++) begin
                chk("dw_wen", 64'(bus.ram_WEN), 64'd1);
                chk("dw_ren", 64'(bus.ram_REN), 64'd0);
                chk("dw_addr", 64'(bus.ram_addr), (w == 1) ? 64'hC : 64'h8);
                chk("dw_data", 64'(bus.ram_store), (w == 1) ? 64'h22 : 64'h11);
                chk("dw_dhit", 64'(bus.dmem_hit), (w == 1 && i == 2) ? 64'd1 : 64'd0);
                chk("dw_ihit", 64'(bus.imem_hit), 64'd0);
                if (w == 1 && i == 2) bus.dmem_WEN = 1'b0;
                cyc();
            end
        end
        chk("dw_idle_wen", 64'(bus.ram_WEN), 64'd0);
        chk("dw_idle_dhit", 64'(bus.dmem_hit), 64'd0);

        // ---- simultaneous requests held: D,D,D,D,I,D,D,D,D,I ----
        ram_hold = 1;
        bus.imem_REN = 1'b1;
        bus.imem_block_addr = 29'h100;
        bus.dmem_REN = 1'b1;
        bus.dmem_block_addr = 29'h200;
        for (int g = 0; g < 10; g++) begin
            chk("st_idle_ren", 64'(bus.ram_REN), 64'd0);
            chk("st_cnt", 64'(dut.r_starve_cnt), (g < 5) ? 64'(g) : 64'(g - 5));
            cyc();
            chk("st_grant_addr", 64'(bus.ram_addr), (g == 4 || g == 9) ? 64'h800 : 64'h1000);
            cyc();
            chk("st_ihit", 64'(bus.imem_hit), (g == 4 || g == 9) ? 64'd1 : 64'd0);
            chk("st_dhit", 64'(bus.dmem_hit), (g == 4 || g == 9) ? 64'd0 : 64'd1);
            cyc();
        end
        bus.imem_REN = 1'b0;
        bus.dmem_REN = 1'b0;
        cyc();

        // ---- icache abort during word1 wait, then pending dcache read ----
        ram_hold = 3;
        rd_base = 32'h50000000;
        bus.imem_REN = 1'b1;
        bus.imem_block_addr = 29'h10;
        cyc();
        bus.dmem_REN = 1'b1;
        bus.dmem_block_addr = 29'h200;
        for (int i = 0; i < 3; i++) begin
            chk("ab_w0_addr", 64'(bus.ram_addr), 64'h80);
            cyc();
        end
        chk("ab_w1_addr", 64'(bus.ram_addr), 64'h84);
        bus.imem_REN = 1'b0;
        cyc();
        chk("ab_w1_hold", 64'(bus.ram_REN), 64'd1);
        chk("ab_w1_addr2", 64'(bus.ram_addr), 64'h84);
        cyc();
        chk("ab_w1_done", 64'(bus.ram_REN), 64'd1);
        chk("ab_no_ihit", 64'(bus.imem_hit), 64'd0);
        cyc();
        chk("ab_idle_ren", 64'(bus.ram_REN), 64'd0);
        chk("ab_idle_ihit", 64'(bus.imem_hit), 64'd0);
        cyc();
        chk("ab_d_addr", 64'(bus.ram_addr), 64'h1000);
        chk("ab_d_ren", 64'(bus.ram_REN), 64'd1);
        for (int i = 0; i < 5; i++) cyc();
        chk("ab_d_hit", 64'(bus.dmem_hit), 64'd1);
        chk("ab_d_load", bus.dmem_load, 64'h50000001_50000000);
        bus.dmem_REN = 1'b0;
        cyc();

        // ---- protocol error: REN and WEN together ----
        ram_hold = 1;
        bus.dmem_REN = 1'b1;
        bus.dmem_WEN = 1'b1;
        bus.dmem_block_addr = 29'h3;
        bus.dmem_store = {32'h44, 32'h33};
        chk("pe_err_before", 64'(DUT_error), 64'd0);
        cyc();
        chk("pe_err_pulse", 64'(DUT_error), 64'd1);
        chk("pe_w0_wen", 64'(bus.ram_WEN), 64'd1);
        chk("pe_w0_ren", 64'(bus.ram_REN), 64'd0);
        chk("pe_w0_addr", 64'(bus.ram_addr), 64'h18);
        chk("pe_w0_data", 64'(bus.ram_store), 64'h33);
        cyc();
        chk("pe_err_clear", 64'(DUT_error), 64'd0);
        chk("pe_w1_addr", 64'(bus.ram_addr), 64'h1C);
        chk("pe_w1_data", 64'(bus.ram_store), 64'h44);
        chk("pe_w1_dhit", 64'(bus.dmem_hit), 64'd1);
        bus.dmem_REN = 1'b0;
        bus.dmem_WEN = 1'b0;
        cyc();
        chk("pe_idle_wen", 64'(bus.ram_WEN), 64'd0);

        // ---- reset during D_W0, then a fresh read ----
        ram_hold = 3;
        rd_base = 32'h60000000;
        bus.dmem_REN = 1'b1;
        bus.dmem_block_addr = 29'h200;
        bus.imem_REN = 1'b1;
        bus.imem_block_addr = 29'h10;
        cyc();
        chk("rm_starve_pre", 64'(dut.r_starve_cnt), 64'd1);
        chk("rm_w0_ren", 64'(bus.ram_REN), 64'd1);
        RST = 1'b1;
        cyc();
        chk("rm_ren", 64'(bus.ram_REN), 64'd0);
        chk("rm_wen", 64'(bus.ram_WEN), 64'd0);
        chk("rm_ihit", 64'(bus.imem_hit), 64'd0);
        chk("rm_dhit", 64'(bus.dmem_hit), 64'd0);
        chk("rm_state", 64'(dut.r_state), 64'd0);
        chk("rm_starve", 64'(dut.r_starve_cnt), 64'd0);
        RST = 1'b0;
        bus.imem_REN = 1'b0;
        ram_hold = 1;
        cyc();
        chk("rm_new_addr", 64'(bus.ram_addr), 64'h1000);
        cyc();
        chk("rm_new_hit", 64'(bus.dmem_hit), 64'd1);
        chk("rm_new_load", bus.dmem_load, 64'h60000001_60000000);
        bus.dmem_REN = 1'b0;
        cyc();
        chk("rm_new_idle", 64'(bus.ram_REN), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
